// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared constants, IR field positions and the fetch state
//               encoding for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    // Default vectors and the all-zero word that decodes as a nop
    localparam logic [31:0] c_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] c_TRAP_VECTOR  = 32'h8000_0200;
    localparam logic [31:0] c_NOP          = 32'h0000_0000;

    // Instruction-word field positions
    localparam int c_OP_HI    = 31;
    localparam int c_OP_LO    = 26;
    localparam int c_RS_HI    = 25;
    localparam int c_RS_LO    = 21;
    localparam int c_RT_HI    = 20;
    localparam int c_RT_LO    = 16;
    localparam int c_FUNCT_HI = 5;
    localparam int c_FUNCT_LO = 0;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetchState_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Multi-cycle fetch stage. Owns PC and IR, fetches one word per
//               P0 strobe over a req/ack bus, handles redirects, traps,
//               misaligned-PC and ack-timeout errors.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = c_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = c_TRAP_VECTOR,
    parameter int          TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        P0,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        pc_load,
    input  logic [31:0] pc_next,
    input  logic        trap,
    output logic [31:0] IR,
    output logic [5:0]  Op,
    output logic [5:0]  IRFunc,
    output logic [4:0]  IRFunc1,
    output logic [4:0]  IRFunc2,
    output logic [31:0] fetch_pc,
    output logic [31:0] PC,
    output logic        ir_valid,
    output logic        fetch_busy,
    output logic        addr_err,
    output logic        bus_err
);

    // Last timer value before the outstanding request is abandoned
    localparam logic [7:0] c_TIMER_LAST = 8'(TIMEOUT - 1);

    fetchState_t r_state;
    fetchState_t w_nextState;

    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_fetchPc;
    logic [31:0] r_reqAddr;
    logic [7:0]  r_timer;
    logic        r_irValid;
    logic        r_discard;
    logic        r_addrErr;
    logic        r_busErr;

    logic        w_startFetch;
    logic        w_ack;
    logic        w_timeout;
    logic        w_misaligned;
    logic        w_redirect;
    logic [31:0] w_redirTarget;
    logic        w_dropData;

    // Trap outranks a branch/jump load when both arrive together
    assign w_redirect    = trap | pc_load;
    assign w_redirTarget = trap ? TRAP_VECTOR : pc_next;
    assign w_misaligned  = (r_pc[1:0] != 2'b00);

    // Returned data is stale if the PC was redirected while it was in flight
    assign w_dropData    = w_redirect | r_discard;

    // Next-state and per-cycle event decode
    always_comb begin
        w_nextState  = r_state;
        w_startFetch = 1'b0;
        w_ack        = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (P0) begin
                    w_startFetch = 1'b1;
                    w_nextState  = w_misaligned ? ST_HOLD : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    w_ack       = 1'b1;
                    w_nextState = ST_HOLD;
                end else if (r_timer == c_TIMER_LAST) begin
                    w_timeout   = 1'b1;
                    w_nextState = ST_HOLD;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // PC, IR, timer and error-pulse datapath
    always_ff @(posedge clk) begin
        if (clr) begin
            r_pc      <= RESET_VECTOR;
            r_ir      <= c_NOP;
            r_fetchPc <= 32'h0;
            r_reqAddr <= 32'h0;
            r_timer   <= 8'h0;
            r_irValid <= 1'b0;
            r_discard <= 1'b0;
            r_addrErr <= 1'b0;
            r_busErr  <= 1'b0;
        end else begin
            r_addrErr <= 1'b0;
            r_busErr  <= 1'b0;

            if (w_startFetch) begin
                r_irValid <= 1'b0;
                if (w_misaligned) begin
                    r_ir      <= c_NOP;
                    r_addrErr <= 1'b1;
                end else begin
                    r_timer   <= 8'h0;
                    r_reqAddr <= r_pc;
                    // A redirect in the launch cycle moves PC away from the
                    // address being fetched, so that word must not be kept.
                    r_discard <= w_redirect;
                end
            end

            if (r_state == ST_REQ) begin
                r_timer <= r_timer + 8'd1;
                if (w_redirect) begin
                    r_discard <= 1'b1;
                end
            end

            if (w_ack) begin
                if (w_dropData) begin
                    r_ir      <= c_NOP;
                    r_irValid <= 1'b0;
                end else begin
                    r_ir      <= mem_rdata;
                    r_fetchPc <= r_reqAddr;
                    r_irValid <= 1'b1;
                end
            end

            if (w_timeout) begin
                r_ir      <= c_NOP;
                r_irValid <= 1'b0;
                r_busErr  <= 1'b1;
            end

            if (w_redirect) begin
                r_pc <= w_redirTarget;
            end else if (w_ack && !r_discard) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    // Address is frozen for the whole request even if PC is redirected
    assign mem_req    = (r_state == ST_REQ);
    assign fetch_busy = (r_state == ST_REQ);
    assign mem_addr   = (r_state == ST_REQ) ? r_reqAddr : r_pc;

    assign IR       = r_ir;
    assign Op       = r_ir[c_OP_HI:c_OP_LO];
    assign IRFunc2  = r_ir[c_RS_HI:c_RS_LO];
    assign IRFunc1  = r_ir[c_RT_HI:c_RT_LO];
    assign IRFunc   = r_ir[c_FUNCT_HI:c_FUNCT_LO];
    assign fetch_pc = r_fetchPc;
    assign PC       = r_pc;
    assign ir_valid = r_irValid;
    assign addr_err = r_addrErr;
    assign bus_err  = r_busErr;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch with a transaction-level
//               reference model and randomized fetch/redirect traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] c_RST_VEC  = 32'hBFC0_0000;
    localparam logic [31:0] c_TRAP_VEC = 32'h8000_0200;
    localparam int          c_TMO      = 16;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        P0 = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_next = 32'h0;
    logic        trap = 1'b0;
    logic [31:0] IR;
    logic [5:0]  Op;
    logic [5:0]  IRFunc;
    logic [4:0]  IRFunc1;
    logic [4:0]  IRFunc2;
    logic [31:0] fetch_pc;
    logic [31:0] PC;
    logic        ir_valid;
    logic        fetch_busy;
    logic        addr_err;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural view after each completed transaction
    logic [31:0] mPc;
    logic [31:0] mIr;
    logic [31:0] mFetchPc;
    logic        mValid;

    instr_fetch #(
        .RESET_VECTOR (c_RST_VEC),
        .TRAP_VECTOR  (c_TRAP_VEC),
        .TIMEOUT      (c_TMO)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .P0         (P0),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .pc_load    (pc_load),
        .pc_next    (pc_next),
        .trap       (trap),
        .IR         (IR),
        .Op         (Op),
        .IRFunc     (IRFunc),
        .IRFunc1    (IRFunc1),
        .IRFunc2    (IRFunc2),
        .fetch_pc   (fetch_pc),
        .PC         (PC),
        .ir_valid   (ir_valid),
        .fetch_busy (fetch_busy),
        .addr_err   (addr_err),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare every output against the model, with expected error pulses
    task automatic checkAll(input string tag, input logic expAddrErr, input logic expBusErr);
        chk({tag, ".IR"},       IR,                       mIr);
        chk({tag, ".Op"},       32'(Op),                  (mIr >> 26) & 32'h3F);
        chk({tag, ".IRFunc2"},  32'(IRFunc2),             (mIr >> 21) & 32'h1F);
        chk({tag, ".IRFunc1"},  32'(IRFunc1),             (mIr >> 16) & 32'h1F);
        chk({tag, ".IRFunc"},   32'(IRFunc),              mIr & 32'h3F);
        chk({tag, ".PC"},       PC,                       mPc);
        chk({tag, ".fetch_pc"}, fetch_pc,                 mFetchPc);
        chk({tag, ".ir_valid"}, 32'(ir_valid),            32'(mValid));
        chk({tag, ".mem_req"},  32'(mem_req),             32'd0);
        chk({tag, ".busy"},     32'(fetch_busy),          32'd0);
        chk({tag, ".mem_addr"}, mem_addr,                 mPc);
        chk({tag, ".addr_err"}, 32'(addr_err),            32'(expAddrErr));
        chk({tag, ".bus_err"},  32'(bus_err),             32'(expBusErr));
    endtask

    task automatic modelReset();
        mPc      = c_RST_VEC;
        mIr      = 32'h0;
        mFetchPc = 32'h0;
        mValid   = 1'b0;
    endtask

    // Redirect while idle; called and returns just after a negedge
    task automatic doRedirect(input logic useTrap, input logic useLoad, input logic [31:0] tgt);
        trap    = useTrap;
        pc_load = useLoad;
        pc_next = tgt;
        @(negedge clk);
        trap    = 1'b0;
        pc_load = 1'b0;
        if (useTrap)      mPc = c_TRAP_VEC;
        else if (useLoad) mPc = tgt;
        checkAll("redir", 1'b0, 1'b0);
    endtask

    // One fetch. redir: 0 none, 1 redirect during the wait, 2 with the ack.
    task automatic doFetch(input logic [31:0] word, input int delay, input int redir,
                           input logic useTrap, input logic [31:0] tgt);
        logic [31:0] reqA;
        logic [31:0] target;
        reqA   = mPc;
        target = useTrap ? c_TRAP_VEC : tgt;
        P0 = 1'b1;
        @(negedge clk);
        P0 = 1'b0;
        chk("req.mem_req", 32'(mem_req), 32'd1);
        chk("req.addr", mem_addr, reqA);
        chk("req.busy", 32'(fetch_busy), 32'd1);
        for (int i = 0; i < delay; i++) begin
            mem_rdata = $urandom();
            P0        = 1'($urandom_range(0, 1));
            if (redir == 1 && i == 0) begin
                trap    = useTrap;
                pc_load = ~useTrap;
                pc_next = tgt;
            end
            @(negedge clk);
            P0      = 1'b0;
            trap    = 1'b0;
            pc_load = 1'b0;
            if (redir == 1 && i == 0) mPc = target;
            chk("wait.mem_req", 32'(mem_req), 32'd1);
            chk("wait.addr", mem_addr, reqA);
        end
        mem_ack   = 1'b1;
        mem_rdata = word;
        if (redir == 2) begin
            trap    = useTrap;
            pc_load = ~useTrap;
            pc_next = tgt;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        trap    = 1'b0;
        pc_load = 1'b0;
        if (redir != 0) begin
            mIr    = 32'h0;
            mValid = 1'b0;
            mPc    = target;
        end else begin
            mIr      = word;
            mFetchPc = reqA;
            mPc      = reqA + 32'd4;
            mValid   = 1'b1;
        end
        checkAll("fetch", 1'b0, 1'b0);
    endtask

    initial begin
        modelReset();
        repeat (2) @(negedge clk);
        clr = 1'b0;
        checkAll("reset", 1'b0, 1'b0);

        // Directed fetch with known decode fields
        doFetch(32'h8C22_0004, 2, 0, 1'b0, 32'h0);
        chk("dir.Op",   32'(Op),      32'h23);
        chk("dir.rs",   32'(IRFunc2), 32'h01);
        chk("dir.rt",   32'(IRFunc1), 32'h02);
        chk("dir.fn",   32'(IRFunc),  32'h04);
        chk("dir.fpc",  fetch_pc,     32'hBFC0_0000);
        chk("dir.pc",   PC,           32'hBFC0_0004);

        // Back-to-back fetches
        for (int i = 0; i < 3; i++) doFetch($urandom(), 0, 0, 1'b0, 32'h0);
        chk("b2b.fpc", fetch_pc, 32'hBFC0_000C);

        // PC wrap at the top of the address space
        doRedirect(1'b0, 1'b1, 32'hFFFF_FFFC);
        doFetch($urandom(), 1, 0, 1'b0, 32'h0);
        chk("wrap.pc", PC, 32'h0000_0000);

        // Redirect coinciding with ack discards the data
        doFetch(32'h1234_5678, 1, 2, 1'b0, 32'h0040_0010);
        chk("redirack.pc", PC, 32'h0040_0010);
        doFetch($urandom(), 0, 0, 1'b0, 32'h0);

        // Trap beats pc_load
        trap = 1'b1; pc_load = 1'b1; pc_next = 32'h0000_1000;
        @(negedge clk);
        trap = 1'b0; pc_load = 1'b0;
        mPc = c_TRAP_VEC;
        checkAll("trapload", 1'b0, 1'b0);

        // Ack timeout
        P0 = 1'b1;
        @(negedge clk);
        P0 = 1'b0;
        for (int i = 1; i < c_TMO; i++) begin
            @(negedge clk);
            chk("tmo.mem_req", 32'(mem_req), 32'd1);
        end
        @(negedge clk);
        mIr = 32'h0; mValid = 1'b0;
        checkAll("tmo", 1'b0, 1'b1);
        @(negedge clk);
        checkAll("tmo.after", 1'b0, 1'b0);

        // Misaligned PC
        doRedirect(1'b0, 1'b1, 32'h0040_0002);
        P0 = 1'b1;
        @(negedge clk);
        P0 = 1'b0;
        mIr = 32'h0; mValid = 1'b0;
        checkAll("misal", 1'b1, 1'b0);
        @(negedge clk);
        checkAll("misal.after", 1'b0, 1'b0);
        doRedirect(1'b0, 1'b1, 32'h0040_0000);

        // Reset in the middle of a request
        doFetch($urandom(), 0, 0, 1'b0, 32'h0);
        P0 = 1'b1;
        @(negedge clk);
        P0 = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        modelReset();
        checkAll("midclr", 1'b0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            int op;
            op = $urandom_range(0, 3);
            case (op)
                0: doFetch($urandom(), $urandom_range(0, 6), 0, 1'b0, 32'h0);
                1: doFetch($urandom(), $urandom_range(1, 5), $urandom_range(1, 2),
                           1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC);
                2: doRedirect(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              $urandom() & 32'hFFFF_FFFC);
                default: begin
                    mem_ack   = 1'b1;
                    mem_rdata = $urandom();
                    @(negedge clk);
                    mem_ack = 1'b0;
                    checkAll("strayack", 1'b0, 1'b0);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
